// File: rtl/cb4_nearest_search.sv
// Sequential nearest-neighbour search over the 16-entry LSP codebook-4 ROM.
// Walks ROM addresses 0..ENTRIES-1 once per request and reports the entry closest to x.
module cb4_nearest_search #(
  parameter int N       = 32,
  parameter int ENTRIES = 16,
  parameter int AW      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  x_in,
  output logic [AW-1:0] rom_addr,
  input  logic [N-1:0]  rom_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] best_idx,
  output logic [N-1:0]  best_val
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t          state, state_nx;
  logic [N-1:0]    x;
  logic [AW-1:0]   cnt;
  logic [N:0]      min_err;
  logic signed [N:0] diff;
  logic [N:0]      err;
  logic            last;

  // One extra bit keeps the full-range subtract from wrapping; |diff| then fits in N+1 unsigned.
  assign diff = $signed({x[N-1], x}) - $signed({rom_data[N-1], rom_data});
  assign err  = diff[N] ? $unsigned(-diff) : $unsigned(diff);
  assign last = (cnt == AW'(ENTRIES-1));

  // cnt doubles as the ROM address, so it naturally holds the last entry between searches.
  assign rom_addr = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SEARCH;
      SEARCH:  if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SEARCH) || (state == DONE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      cnt      <= '0;
      min_err  <= '0;
      best_idx <= '0;
      best_val <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x       <= x_in;
          cnt     <= '0;
          min_err <= '1;
        end
        SEARCH: begin
          // Strict compare: ties keep the earlier (lower) index.
          if (err < min_err) begin
            min_err  <= err;
            best_idx <= cnt;
            best_val <= rom_data;
          end
          if (!last) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cb4_nearest_search.sv
// Directed bench for cb4_nearest_search with a behavioural codebook ROM (950 + 100*i Hz, Q15.16).
module tb_cb4_nearest_search;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] x_in;
  logic [3:0]  rom_addr;
  logic [31:0] rom_data;
  logic        busy, done;
  logic [3:0]  best_idx;
  logic [31:0] best_val;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] cb(input int i);
    logic [15:0] hz;
    hz = 16'(950 + 100 * i);
    return {hz, 16'h0000};
  endfunction

  assign rom_data = cb(int'(rom_addr));

  cb4_nearest_search dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .done(done), .best_idx(best_idx), .best_val(best_val)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: exhaustive search with 64-bit arithmetic.
  function automatic int nearest(input logic [31:0] xv);
    longint xs, d, bd;
    int bi;
    xs = longint'($signed(xv));
    bd = 64'h7FFF_FFFF_FFFF_FFFF;
    bi = 0;
    for (int i = 0; i < 16; i++) begin
      d = xs - longint'($signed(cb(i)));
      if (d < 0) d = -d;
      if (d < bd) begin bd = d; bi = i; end
    end
    return bi;
  endfunction

  // Pulse start from IDLE; returns the cycle (1 = first cycle after the accepting edge) done was seen.
  task automatic do_search(input string tag, input logic [31:0] xv, input int exp_idx,
                           input logic [31:0] exp_val);
    int lat;
    @(negedge clk);
    start = 1'b1; x_in = xv;
    @(negedge clk);
    start = 1'b0; x_in = 32'h0;
    lat = 1;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd17);
    chk({tag, "_idx"}, 64'(best_idx), 64'(exp_idx));
    chk({tag, "_val"}, 64'(best_val), 64'(exp_val));
    @(negedge clk);
    chk({tag, "_donefall"}, 64'({busy, done}), 64'd0);
    chk({tag, "_hold"}, 64'(best_idx), 64'(exp_idx));
  endtask

  initial begin
    int ndone, idx_at_done, busy_bad;
    logic [31:0] xr;
    rst = 1'b1; start = 1'b0; x_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_idx",  64'(best_idx), 64'd0);
    chk("rst_val",  64'(best_val), 64'd0);
    chk("rst_addr", 64'(rom_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Ties and normal lookups
    do_search("tie1000", 32'h03E8_0000, 0,  32'h03B6_0000);
    chk("addr_hold", 64'(rom_addr), 64'd15);
    do_search("x2400",   32'h0960_8000, 15, 32'h0992_0000);
    do_search("tie1500", 32'h05DC_0000, 5,  32'h05AA_0000);
    do_search("x1234",   32'h04D2_0000, 3,  32'h04E2_0000);

    // Out-of-range and full-range extremes
    do_search("neg100",  32'hFF9C_0000, 0,  32'h03B6_0000);
    do_search("big",     32'h7FFF_0000, 15, 32'h0992_0000);
    do_search("minneg",  32'h8000_0000, 0,  32'h03B6_0000);
    do_search("maxpos",  32'h7FFF_FFFF, 15, 32'h0992_0000);

    // Start while busy is ignored
    @(negedge clk);
    start = 1'b1; x_in = 32'h03E8_0000;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; busy_bad = 0; idx_at_done = -1;
    for (int c = 1; c <= 30; c++) begin
      if (c == 5) begin start = 1'b1; x_in = 32'h0960_8000; end
      if (c == 6) begin start = 1'b0; x_in = 32'h0; end
      if (c <= 17 && !busy) busy_bad++;
      if (done) begin ndone++; idx_at_done = int'(best_idx); end
      if (c == 17) chk("ign_done17", 64'(done), 64'd1);
      @(negedge clk);
    end
    chk("ign_ndone", 64'(ndone), 64'd1);
    chk("ign_busy",  64'(busy_bad), 64'd0);
    chk("ign_idx",   64'(idx_at_done), 64'd0);

    // Asynchronous reset mid-search
    @(negedge clk);
    start = 1'b1; x_in = 32'h0960_8000;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_idx",  64'(best_idx), 64'd0);
    chk("arst_val",  64'(best_val), 64'd0);
    chk("arst_addr", 64'(rom_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    chk("arst_quiet", 64'(ndone), 64'd0);
    do_search("post_rst", 32'h05DC_0000, 5, 32'h05AA_0000);

    // Back-to-back with start held high; accepts every 18 cycles
    @(negedge clk);
    start = 1'b1;
    for (int s = 0; s < 5; s++) begin
      int e;
      chk("b2b_idle", 64'(busy), 64'd0);
      xr = {16'($urandom_range(800, 2600)), 16'($urandom_range(0, 65535))};
      x_in = xr;
      e = nearest(xr);
      @(negedge clk);
      x_in = ~xr;
      ndone = 0; busy_bad = 0;
      for (int k = 1; k <= 16; k++) begin
        chk("b2b_addr", 64'(rom_addr), 64'(k - 1));
        if (!busy) busy_bad++;
        if (done) ndone++;
        @(negedge clk);
      end
      chk("b2b_busy",  64'(busy_bad), 64'd0);
      chk("b2b_early", 64'(ndone), 64'd0);
      chk("b2b_done",  64'(done), 64'd1);
      chk("b2b_idx",   64'(best_idx), 64'(e));
      chk("b2b_val",   64'(best_val), 64'(cb(e)));
      @(negedge clk);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
